// File: rtl/uart_pkg.sv
// Shared constants and TX state encoding for the UART FIFO controller.
package uart_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int AW_DEF       = 4;

    localparam int CLK_FREQ_28M = 28000000;
    localparam int CLK_FREQ_24M = 24000000;
    localparam int BPS          = 115200;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_BUSY  = 2'd2,
        T_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO, first-word fall-through, AW+1 bit wrapping pointers.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // A pop frees a slot in the same cycle, so a push alongside it is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// CPU-side TX/RX byte FIFOs with transmitter start FSM and receiver holding register.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk_bus,
    input  logic          reset,
    input  logic          cpu_wr_en,
    input  logic [7:0]    cpu_wr_data,
    input  logic          cpu_rd_en,
    output logic [7:0]    cpu_rd_data,
    input  logic          ovr_clr,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          rx_full,
    output logic          rx_empty,
    output logic [AW:0]   rx_count,
    output logic          rx_ovr,
    output logic          txbegin,
    output logic [7:0]    txdata,
    input  logic          txbusy,
    input  logic          rxrecv,
    input  logic [7:0]    rxdata,
    output logic          data_read
);

    tx_state_t   state;
    tx_state_t   state_next;
    logic        tx_pop;
    logic        begin_nxt;
    logic [7:0]  tx_head;
    logic [AW:0] tx_count;

    logic [7:0]  hold;
    logic        pending;
    logic        drain;
    logic        ovr_set;

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk       (clk_bus),
        .reset     (reset),
        .push      (cpu_wr_en),
        .push_data (cpu_wr_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk       (clk_bus),
        .reset     (reset),
        .push      (drain),
        .push_data (hold),
        .pop       (cpu_rd_en),
        .head      (cpu_rd_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // TX state register.
    always_ff @(posedge clk_bus) begin
        if (reset) state <= T_IDLE;
        else       state <= state_next;
    end

    // TX next state: start only while the transmitter is idle, then follow its busy level
    // up and back down so each frame is fully acknowledged before the next begin.
    always_comb begin
        state_next = state;
        case (state)
            T_IDLE:  if ((tx_count != '0) && !txbusy) state_next = T_START;
            T_START: state_next = T_BUSY;
            T_BUSY:  if (txbusy)  state_next = T_DONE;
            T_DONE:  if (!txbusy) state_next = T_IDLE;
            default: state_next = T_IDLE;
        endcase
    end

    // TX outputs: entering T_START pops the head and raises txbegin for that one state.
    always_comb begin
        begin_nxt = (state_next == T_START);
        tx_pop    = begin_nxt;
    end

    // Registered TX handshake; txdata only changes when a new byte is launched.
    always_ff @(posedge clk_bus) begin
        if (reset) begin
            txbegin <= 1'b0;
            txdata  <= 8'h00;
        end else begin
            txbegin <= begin_nxt;
            if (tx_pop) txdata <= tx_head;
        end
    end

    // The held byte moves into the RX FIFO whenever there is room; while full, data_read
    // stays low so the receiver stalls.
    assign drain   = pending && !rx_full;
    // A byte is lost only when the held one cannot leave in the same cycle.
    assign ovr_set = rxrecv && pending && !drain;

    // RX holding register, acknowledge pulse and sticky overrun (set beats clear).
    always_ff @(posedge clk_bus) begin
        if (reset) begin
            hold      <= 8'h00;
            pending   <= 1'b0;
            data_read <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            if (rxrecv) begin
                hold    <= rxdata;
                pending <= 1'b1;
            end else if (drain) begin
                pending <= 1'b0;
            end
            data_read <= drain;
            if (ovr_set)      rx_ovr <= 1'b1;
            else if (ovr_clr) rx_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: TX bytes checked at txbegin, RX bytes at CPU pops.
module tb_uart_fifo_ctrl;

    logic       clk_bus;
    logic       reset;
    logic       cpu_wr_en;
    logic [7:0] cpu_wr_data;
    logic       cpu_rd_en;
    logic [7:0] cpu_rd_data;
    logic       ovr_clr;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [4:0] rx_count;
    logic       rx_ovr;
    logic       txbegin;
    logic [7:0] txdata;
    logic       txbusy;
    logic       rxrecv;
    logic [7:0] rxdata;
    logic       data_read;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic       tx_force;
    int         busy_cnt;
    logic       prev_txbusy;
    logic       prev_txbegin;

    uart_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk_bus     (clk_bus),
        .reset       (reset),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_rd_data (cpu_rd_data),
        .ovr_clr     (ovr_clr),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .rx_full     (rx_full),
        .rx_empty    (rx_empty),
        .rx_count    (rx_count),
        .rx_ovr      (rx_ovr),
        .txbegin     (txbegin),
        .txdata      (txdata),
        .txbusy      (txbusy),
        .rxrecv      (rxrecv),
        .rxdata      (rxdata),
        .data_read   (data_read)
    );

    initial begin
        clk_bus = 1'b0;
        forever #5 clk_bus = ~clk_bus;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive point: just after the active edge.
    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tick();
        cpu_wr_en   = 1'b1;
        cpu_wr_data = d;
        tick();
        cpu_wr_en   = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic clr);
        tick();
        rxrecv  = 1'b1;
        rxdata  = d;
        ovr_clr = clr;
        tick();
        rxrecv  = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic cpu_read();
        tick();
        cpu_rd_en = 1'b1;
        tick();
        cpu_rd_en = 1'b0;
    endtask

    task automatic wait_rx();
        int k = 0;
        while (rx_empty && k < 20) begin
            @(negedge clk_bus);
            k++;
        end
        check("rx_wait_timeout", (k >= 20), 0);
    endtask

    task automatic wait_tx_drain(input int limit);
        int k = 0;
        while ((tx_exp.size() != 0 || txbusy) && k < limit) begin
            @(negedge clk_bus);
            k++;
        end
        check("tx_drain_timeout", (k >= limit), 0);
    endtask

    // Transmitter model: busy for four cycles after each txbegin, or held high by tx_force.
    initial begin
        txbusy   = 1'b0;
        busy_cnt = 0;
        forever begin
            @(posedge clk_bus);
            #1;
            if (txbegin)           busy_cnt = 4;
            else if (busy_cnt > 0) busy_cnt--;
            txbusy = tx_force || (busy_cnt > 0);
        end
    end

    // Monitor: every launched byte and every CPU pop is compared against the scoreboard.
    initial begin
        prev_txbusy  = 1'b0;
        prev_txbegin = 1'b0;
        forever begin
            @(negedge clk_bus);
            if (txbegin === 1'b1) begin
                check("tx_gap", {prev_txbegin, prev_txbusy}, 2'b00);
                if (tx_exp.size() == 0) check("tx_unexpected", {24'h0, txdata}, 32'h1ff);
                else                    check("txdata", txdata, tx_exp.pop_front());
            end
            if (cpu_rd_en === 1'b1 && rx_empty === 1'b0) begin
                if (rx_exp.size() == 0) check("rx_unexpected", {24'h0, cpu_rd_data}, 32'h1ff);
                else                    check("rd_data", cpu_rd_data, rx_exp.pop_front());
            end
            prev_txbusy  = txbusy;
            prev_txbegin = txbegin;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_wr_en = 1'b0; cpu_wr_data = 8'h00; cpu_rd_en = 1'b0;
        ovr_clr = 1'b0; rxrecv = 1'b0; rxdata = 8'h00; tx_force = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk_bus);
        check("rst_tx_empty",  tx_empty,  1);
        check("rst_rx_empty",  rx_empty,  1);
        check("rst_tx_full",   tx_full,   0);
        check("rst_rx_full",   rx_full,   0);
        check("rst_rx_count",  rx_count,  0);
        check("rst_rx_ovr",    rx_ovr,    0);
        check("rst_txbegin",   txbegin,   0);
        check("rst_txdata",    txdata,    8'h00);
        check("rst_data_read", data_read, 0);

        // Single byte: txbegin one cycle after the push
        tx_exp.push_back(8'h55);
        push(8'h55);
        @(negedge clk_bus);
        check("tx_not_early", txbegin, 0);
        @(negedge clk_bus);
        check("tx_latency", txbegin, 1);
        check("tx_latency_data", txdata, 8'h55);
        wait_tx_drain(100);

        // Fill TX with transmitter busy, drop the 17th, then drain in order
        tick();
        tx_force = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tx_exp.push_back(8'(i));
            push(8'(i));
        end
        @(negedge clk_bus);
        check("tx_full_16", tx_full, 1);
        push(8'hFF);
        @(negedge clk_bus);
        check("tx_full_drop", tx_full, 1);
        check("tx_no_begin_busy", txbegin, 0);
        tick();
        tx_force = 1'b0;
        wait_tx_drain(400);
        check("tx_empty_after", tx_empty, 1);

        // RX single byte
        rx_exp.push_back(8'hA5);
        rx_send(8'hA5, 1'b0);
        @(negedge clk_bus);
        check("rx_dr_not_early", data_read, 0);
        @(negedge clk_bus);
        check("rx_data_read", data_read, 1);
        check("rx_not_empty", rx_empty, 0);
        check("rx_head", cpu_rd_data, 8'hA5);
        cpu_read();
        @(negedge clk_bus);
        check("rx_empty_after", rx_empty, 1);

        // Fill RX, then a held byte stalls until a pop makes room
        for (int i = 0; i < 16; i++) begin
            rx_exp.push_back(8'h10 + 8'(i));
            rx_send(8'h10 + 8'(i), 1'b0);
        end
        tick();
        @(negedge clk_bus);
        check("rx_full_16", rx_full, 1);
        check("rx_count_16", rx_count, 16);
        rx_exp.push_back(8'h3C);
        rx_send(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_bus);
            check("rx_stall_dr", data_read, 0);
        end
        check("rx_stall_full", rx_full, 1);
        cpu_read();
        @(negedge clk_bus);
        check("rx_release_room", rx_full, 0);
        check("rx_release_dr0", data_read, 0);
        @(negedge clk_bus);
        check("rx_release_dr1", data_read, 1);
        check("rx_release_full", rx_full, 1);

        // Overrun: E1 held, 77 overwrites it while ovr_clr is also asserted
        rx_send(8'hE1, 1'b0);
        @(negedge clk_bus);
        check("ovr_not_yet", rx_ovr, 0);
        rx_exp.push_back(8'h77);
        rx_send(8'h77, 1'b1);
        @(negedge clk_bus);
        check("ovr_set_wins", rx_ovr, 1);
        tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        @(negedge clk_bus);
        check("ovr_cleared", rx_ovr, 0);
        for (int i = 0; i < 17; i++) begin
            wait_rx();
            cpu_read();
        end
        tick();
        @(negedge clk_bus);
        check("rx_drained_empty", rx_empty, 1);
        check("rx_drained_count", rx_count, 0);

        // Reset with txbusy high, 3 TX bytes queued and a byte arriving
        tick();
        tx_force = 1'b1;
        tick();
        tick();
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        @(negedge clk_bus);
        check("pre_rst_tx_queued", tx_empty, 0);
        tick();
        reset  = 1'b1;
        rxrecv = 1'b1;
        rxdata = 8'h99;
        tick();
        rxrecv = 1'b0;
        tick();
        reset  = 1'b0;
        @(negedge clk_bus);
        check("rst2_tx_empty", tx_empty, 1);
        check("rst2_rx_empty", rx_empty, 1);
        check("rst2_txbegin",  txbegin,  0);
        check("rst2_txdata",   txdata,   8'h00);
        tick();
        tick();
        @(negedge clk_bus);
        check("rst2_rx_discard", rx_empty, 1);
        tx_exp.push_back(8'hB7);
        push(8'hB7);
        repeat (5) @(negedge clk_bus);
        check("rst2_tx_held", tx_empty, 0);
        tick();
        tx_force = 1'b0;
        wait_tx_drain(100);
        rx_exp.push_back(8'h5A);
        rx_send(8'h5A, 1'b0);
        wait_rx();
        cpu_read();
        tick();

        check("tx_exp_left", tx_exp.size(), 0);
        check("rx_exp_left", rx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, meaning entries per FIFO; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, meaning pointer width; SHALL equal log2(DEPTH).
REQ-003 clk_bus  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_wr_en  in  1  one-cycle request to push cpu_wr_data into the TX FIFO.
REQ-006 cpu_wr_data  in  8  byte to transmit.
REQ-007 cpu_rd_en  in  1  one-cycle request to pop the RX FIFO head.
REQ-008 cpu_rd_data  out  8  RX FIFO head, first-word fall-through.
REQ-009 ovr_clr  in  1  clears the sticky overrun flag.
REQ-010 tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO status.
REQ-011 rx_count  out  AW+1  RX FIFO occupancy.
REQ-012 rx_ovr  out  1  sticky flag: a received byte was lost.
REQ-013 txbegin  out  1; txdata  out  8; txbusy  in  1  transmitter handshake.
REQ-014 rxrecv  in  1; rxdata  in  8; data_read  out  1  receiver handshake.

Function
REQ-015 A push with tx_full=1 SHALL be ignored. Push and pop in the same cycle SHALL both take effect.
REQ-016 The TX FSM SHALL have states T_IDLE, T_START, T_BUSY and T_DONE.
- T_IDLE to T_START: tx_empty=0 and txbusy=0.
- T_START: txbegin=1 for exactly one cycle; txdata = FIFO head; head popped this cycle.
- T_BUSY: txbegin=0; wait for txbusy=1.
- T_DONE: wait for txbusy=0, then go to T_IDLE.
REQ-017 txdata SHALL be registered and held stable from T_START until the FSM returns to T_IDLE.
REQ-018 txbegin SHALL be 0 in every state other than T_START. This guarantees the low level the transmitter requires to advance.
REQ-019 Back-to-back bytes SHALL start at least 1 cycle after txbusy falls.
REQ-020 The RX path SHALL have a one-byte holding register with a pending flag.
- When rxrecv=1: latch rxdata into the holding register and set pending.
REQ-021 When pending=1 and rx_full=0, the RX path SHALL, in the same cycle:
- push the holding register into the RX FIFO;
- pulse data_read=1 for one cycle;
- clear pending.
REQ-022 While pending=1 and rx_full=1, data_read SHALL stay 0. This holds the receiver in its wait state, keeps rts asserted, and provides flow control.
REQ-023 If rxrecv=1 while pending=1, the new byte SHALL overwrite the holding register and rx_ovr SHALL set.
REQ-024 ovr_clr SHALL clear rx_ovr. If ovr_clr and a new overrun occur in the same cycle, set SHALL win.
REQ-025 A pop with rx_empty=1 SHALL be ignored. cpu_rd_data SHALL be undefined-but-stable when the FIFO is empty.
REQ-026 RX pushes from the holding register and CPU pops in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-027 Pointers SHALL be AW+1 bits and wrap modulo 2*DEPTH.
- full: MSBs differ, low bits equal.
- empty: pointers equal.
- rx_count = wr_ptr - rd_ptr, truncated to AW+1 bits.
REQ-028 All outputs SHALL be registered, except cpu_rd_data and the status flags, which are decoded from registered pointers.

Reset
REQ-029 On reset SHALL:
- set FIFO pointers to 0: tx_empty=1, rx_empty=1, tx_full=0, rx_full=0, rx_count=0;
- set the TX FSM to T_IDLE with txbegin=0 and txdata=8'h00;
- clear pending, set data_read=0 and rx_ovr=0.
REQ-030 After reset, no new txbegin SHALL be issued until txbusy=0. The transmitter has no reset and may still be mid-frame.
REQ-031 A byte pending in the receiver at reset SHALL be discarded. The first rxrecv after reset SHALL be handled normally.

Structure
REQ-032 A shared package uart_pkg SHALL hold:
- the TX state encoding (2 bits);
- DEPTH and AW defaults;
- the clock constants 28000000 and 24000000 and BPS 115200.
REQ-033 One sub-module, sync_fifo (parameters DEPTH, AW; 8-bit data), SHALL be instantiated twice, for TX and RX.
REQ-034 The RTL SHALL contain no latches, no asynchronous logic, and no multi-cycle paths.

Verification
REQ-035 Push 8'h55 with txbusy modelled:
- txbegin pulses 1 cycle later with txdata=8'h55;
- no second txbegin until the model drops txbusy.
REQ-036 Push 16 bytes 00..0F with txbusy held high:
- tx_full=1 after the 16th push;
- a 17th push (8'hFF) is dropped;
- the bytes are then transmitted in order 00..0F.
REQ-037 rxrecv with rxdata=8'hA5:
- data_read pulses 1 cycle after rxrecv;
- rx_empty=0 and cpu_rd_data=8'hA5;
- after cpu_rd_en, rx_empty=1.
REQ-038 Fill the RX FIFO (16 bytes), then rxrecv with 8'h3C:
- data_read stays 0;
- one cpu_rd_en releases it: push of 8'h3C and a data_read pulse in the following cycle.
REQ-039 With the FIFO full and pending=1, a second rxrecv with 8'h77:
- rx_ovr=1 and the holding register=8'h77;
- ovr_clr then returns rx_ovr to 0.
REQ-040 Assert reset while txbusy=1 and 3 TX bytes are queued:
- FIFOs empty, txbegin=0 throughout;
- a byte pushed after reset starts only after txbusy falls.
